// File: rtl/onewire_rom_sequencer.sv
// rtl/onewire_rom_sequencer.sv - 1-Wire ROM/function command sequencer over a byte engine
module onewire_rom_sequencer #(
  parameter logic [63:0] ROM_ID        = 64'h2800_0000_0012_3401,
  parameter int          SCRATCH_BYTES = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       bus_rst,
  input  logic [7:0]                 rx_byte,
  input  logic                       rx_valid,
  input  logic                       tx_done,
  output logic [7:0]                 tx_byte,
  output logic                       tx_start,
  output logic                       dir,
  input  logic [8*SCRATCH_BYTES-1:0] scratch_rd,
  output logic [7:0]                 wr_data,
  output logic [2:0]                 wr_addr,
  output logic                       wr_en,
  output logic                       selected
);

  typedef enum logic [2:0] {
    WAIT_RST, ROM_CMD, READ_ROM, MATCH_ROM, FUNC_CMD, TX_DATA, RX_DATA
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [3:0]  cnt_nxt;
  logic [63:0] scratch_ext;
  logic [7:0]  rom_cur;
  logic [7:0]  rom_nxt;
  logic [7:0]  scr_nxt;

  localparam logic [3:0] LAST_SCR = 4'(SCRATCH_BYTES - 1);

  // Zero-extend so byte selects stay in range for any scratchpad length.
  assign scratch_ext = 64'(scratch_rd);
  assign cnt_nxt     = cnt + 4'd1;
  assign rom_cur     = ROM_ID[{cnt[2:0], 3'b000} +: 8];
  assign rom_nxt     = ROM_ID[{cnt_nxt[2:0], 3'b000} +: 8];
  assign scr_nxt     = scratch_ext[{cnt_nxt[2:0], 3'b000} +: 8];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= WAIT_RST;
      cnt      <= 4'd0;
      tx_byte  <= 8'd0;
      tx_start <= 1'b0;
      dir      <= 1'b0;
      wr_data  <= 8'd0;
      wr_addr  <= 3'd0;
      wr_en    <= 1'b0;
      selected <= 1'b0;
    end else begin
      tx_start <= 1'b0;
      wr_en    <= 1'b0;
      if (bus_rst) begin
        // Bus reset wins over any same-cycle byte event and abandons a transmit.
        state    <= ROM_CMD;
        cnt      <= 4'd0;
        dir      <= 1'b0;
        selected <= 1'b0;
      end else begin
        case (state)
          WAIT_RST: ;
          ROM_CMD: if (rx_valid) begin
            cnt <= 4'd0;
            case (rx_byte)
              8'h33: begin
                state    <= READ_ROM;
                dir      <= 1'b1;
                tx_byte  <= ROM_ID[7:0];
                tx_start <= 1'b1;
              end
              8'h55: state <= MATCH_ROM;
              8'hCC: begin
                state    <= FUNC_CMD;
                selected <= 1'b1;
              end
              default: state <= WAIT_RST;
            endcase
          end
          READ_ROM: if (tx_done) begin
            if (cnt == 4'd7) begin
              state    <= FUNC_CMD;
              cnt      <= 4'd0;
              dir      <= 1'b0;
              selected <= 1'b1;
            end else begin
              cnt      <= cnt_nxt;
              tx_byte  <= rom_nxt;
              tx_start <= 1'b1;
            end
          end
          MATCH_ROM: if (rx_valid) begin
            if (rx_byte != rom_cur) begin
              state <= WAIT_RST;
            end else if (cnt == 4'd7) begin
              state    <= FUNC_CMD;
              cnt      <= 4'd0;
              selected <= 1'b1;
            end else begin
              cnt <= cnt_nxt;
            end
          end
          FUNC_CMD: if (rx_valid) begin
            cnt <= 4'd0;
            case (rx_byte)
              8'hBE: begin
                state    <= TX_DATA;
                dir      <= 1'b1;
                tx_byte  <= scratch_ext[7:0];
                tx_start <= 1'b1;
              end
              8'h4E: state <= RX_DATA;
              default: begin
                state    <= WAIT_RST;
                selected <= 1'b0;
              end
            endcase
          end
          TX_DATA: if (tx_done) begin
            if (cnt == LAST_SCR) begin
              state    <= WAIT_RST;
              dir      <= 1'b0;
              selected <= 1'b0;
            end else begin
              cnt      <= cnt_nxt;
              tx_byte  <= scr_nxt;
              tx_start <= 1'b1;
            end
          end
          RX_DATA: if (rx_valid) begin
            wr_en   <= 1'b1;
            wr_data <= rx_byte;
            wr_addr <= cnt[2:0];
            cnt     <= cnt_nxt;
            if (cnt == LAST_SCR) begin
              state    <= WAIT_RST;
              selected <= 1'b0;
            end
          end
          default: state <= WAIT_RST;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_onewire_rom_sequencer.sv
// tb/tb_onewire_rom_sequencer.sv - scoreboard bench for onewire_rom_sequencer
module tb_onewire_rom_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        bus_rst = 1'b0;
  logic [7:0]  rx_byte = 8'd0;
  logic        rx_valid = 1'b0;
  logic        tx_done = 1'b0;
  logic [7:0]  tx_byte;
  logic        tx_start;
  logic        dir;
  logic [63:0] scratch_rd = 64'h8877665544332211;
  logic [7:0]  wr_data;
  logic [2:0]  wr_addr;
  logic        wr_en;
  logic        selected;

  int n_pass = 0;
  int n_total = 0;

  typedef struct packed {
    logic       is_wr;
    logic [2:0] addr;
    logic [7:0] data;
  } ev_t;
  ev_t sb[$];

  logic [7:0] rom_bytes [8] = '{8'h01, 8'h34, 8'h12, 8'h00, 8'h00, 8'h00, 8'h00, 8'h28};
  logic [7:0] scr_bytes [8] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88};
  logic [7:0] wr_bytes  [9] = '{8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h0F, 8'hF0, 8'h99, 8'h66, 8'hEE};

  onewire_rom_sequencer dut (
    .clk(clk), .reset(reset), .bus_rst(bus_rst), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .tx_done(tx_done), .tx_byte(tx_byte), .tx_start(tx_start), .dir(dir),
    .scratch_rd(scratch_rd), .wr_data(wr_data), .wr_addr(wr_addr), .wr_en(wr_en),
    .selected(selected)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s got %0h expected %0h", name, act, exp);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_rx(input logic [7:0] b);
    @(negedge clk); rx_byte = b; rx_valid = 1'b1;
    @(negedge clk); rx_valid = 1'b0;
    idle(2);
  endtask

  task automatic send_bus_rst();
    @(negedge clk); bus_rst = 1'b1;
    @(negedge clk); bus_rst = 1'b0;
    idle(1);
  endtask

  task automatic send_tx_done();
    @(negedge clk); tx_done = 1'b1;
    @(negedge clk); tx_done = 1'b0;
    idle(2);
  endtask

  task automatic push_tx(input logic [7:0] b);
    sb.push_back('{is_wr: 1'b0, addr: 3'd0, data: b});
  endtask

  task automatic push_wr(input logic [2:0] a, input logic [7:0] b);
    sb.push_back('{is_wr: 1'b1, addr: a, data: b});
  endtask

  // Monitor: every tx_start or wr_en must match the oldest expected event.
  initial begin
    ev_t e;
    forever begin
      @(posedge clk); #1;
      if (!reset && tx_start) begin
        if (sb.size() == 0) chk("unexpected_tx_start", {24'd0, tx_byte}, 32'hFFFF);
        else begin
          e = sb.pop_front();
          chk("ev_kind_tx", 32'(e.is_wr), 32'd0);
          chk("tx_byte", {24'd0, tx_byte}, {24'd0, e.data});
          chk("dir_during_tx", {31'd0, dir}, 32'd1);
        end
      end
      if (!reset && wr_en) begin
        if (sb.size() == 0) chk("unexpected_wr_en", {24'd0, wr_data}, 32'hFFFF);
        else begin
          e = sb.pop_front();
          chk("ev_kind_wr", 32'(e.is_wr), 32'd1);
          chk("wr_data", {24'd0, wr_data}, {24'd0, e.data});
          chk("wr_addr", {29'd0, wr_addr}, {29'd0, e.addr});
        end
      end
    end
  end

  initial begin
    idle(2);
    chk("rst_tx_byte", {24'd0, tx_byte}, 32'd0);
    chk("rst_tx_start", {31'd0, tx_start}, 32'd0);
    chk("rst_dir", {31'd0, dir}, 32'd0);
    chk("rst_wr", {20'd0, wr_en, wr_addr, wr_data}, 32'd0);
    chk("rst_selected", {31'd0, selected}, 32'd0);
    reset = 1'b0;
    idle(2);

    // 1: Read ROM
    send_bus_rst();
    for (int i = 0; i < 8; i++) push_tx(rom_bytes[i]);
    send_rx(8'h33);
    for (int i = 0; i < 8; i++) send_tx_done();
    chk("t1_dir_after", {31'd0, dir}, 32'd0);
    chk("t1_selected", {31'd0, selected}, 32'd1);

    // 2: Match ROM then read scratchpad
    send_bus_rst();
    send_rx(8'h55);
    for (int i = 0; i < 8; i++) send_rx(rom_bytes[i]);
    chk("t2_selected_match", {31'd0, selected}, 32'd1);
    for (int i = 0; i < 8; i++) push_tx(scr_bytes[i]);
    send_rx(8'hBE);
    for (int i = 0; i < 8; i++) send_tx_done();
    chk("t2_selected_end", {31'd0, selected}, 32'd0);
    chk("t2_dir_end", {31'd0, dir}, 32'd0);

    // 3: Match ROM mismatch on second byte
    send_bus_rst();
    send_rx(8'h55);
    send_rx(8'h01);
    send_rx(8'h35);
    chk("t3_selected", {31'd0, selected}, 32'd0);
    send_rx(8'hBE);

    // 4: Skip ROM, write scratchpad, ninth byte dropped
    send_bus_rst();
    send_rx(8'hCC);
    send_rx(8'h4E);
    for (int i = 0; i < 8; i++) push_wr(3'(i), wr_bytes[i]);
    for (int i = 0; i < 9; i++) send_rx(wr_bytes[i]);
    chk("t4_selected_end", {31'd0, selected}, 32'd0);

    // 5: bus reset in the middle of Read ROM
    send_bus_rst();
    for (int i = 0; i < 4; i++) push_tx(rom_bytes[i]);
    send_rx(8'h33);
    for (int i = 0; i < 3; i++) send_tx_done();
    send_bus_rst();
    chk("t5_dir", {31'd0, dir}, 32'd0);
    send_tx_done();
    send_rx(8'hCC);
    chk("t5_selected", {31'd0, selected}, 32'd1);

    // 6: async reset mid write, then bus_rst colliding with rx_valid
    send_rx(8'h4E);
    push_wr(3'd0, 8'hA5);
    send_rx(8'hA5);
    @(negedge clk); rx_byte = 8'h77; rx_valid = 1'b1; reset = 1'b1;
    #1;
    chk("t6_async_wr", {20'd0, wr_en, wr_addr, wr_data}, 32'd0);
    chk("t6_async_sel_dir", {30'd0, selected, dir}, 32'd0);
    chk("t6_async_tx", {23'd0, tx_start, tx_byte}, 32'd0);
    @(negedge clk); rx_valid = 1'b0;
    @(negedge clk); reset = 1'b0;
    idle(2);
    @(negedge clk); bus_rst = 1'b1; rx_byte = 8'hCC; rx_valid = 1'b1;
    @(negedge clk); bus_rst = 1'b0; rx_valid = 1'b0;
    idle(2);
    chk("t6_collide_sel", {31'd0, selected}, 32'd0);
    send_rx(8'h4E);
    send_rx(8'h11);
    chk("t6_no_select", {31'd0, selected}, 32'd0);

    idle(4);
    chk("scoreboard_drained", sb.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
